// File: rtl/vec_dec_pkg.sv
// Shared definitions for the vector micro-op sequencer: FSM states,
// instruction field positions and the ALU no-op encoding.
package vec_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int ALU_LSB = 0;
  localparam int ALU_MSB = 3;

  localparam logic [3:0] ALU_NOP = 4'hF;

endpackage

// File: rtl/vec_lane_mask_gen.sv
// Combinational lane-mask / last-beat generator for one lane group
// starting at elem_base within a vector of length vl.
module vec_lane_mask_gen #(
  parameter int NUM_LANES = 4,
  parameter int VL_W      = 5
) (
  input  logic [VL_W-1:0]      elem_base,
  input  logic [VL_W-1:0]      vl,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic                 uop_last
);

  // One extra bit so elem_base + NUM_LANES never wraps.
  localparam logic [VL_W:0] LANES_EXT = (VL_W+1)'(NUM_LANES);

  logic [VL_W:0] base_ext;
  logic [VL_W:0] vl_ext;

  assign base_ext = {1'b0, elem_base};
  assign vl_ext   = {1'b0, vl};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [VL_W:0] OFS = (VL_W+1)'(gi);
      assign lane_mask[gi] = (base_ext + OFS) < vl_ext;
    end
  endgenerate

  assign uop_last = (base_ext + LANES_EXT) >= vl_ext;

endmodule

// File: rtl/vec_uop_sequencer.sv
// Vector decode stage: splits one instruction into lane-group micro-ops.
// Define VEC_SEQ_BACK2BACK_EN to accept a new instruction on the last beat.
module vec_uop_sequencer
  import vec_dec_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int MAX_VL    = 16,
  parameter int REG_AW    = 5,
  parameter int ALU_CW    = 4,
  parameter int VL_W      = $clog2(MAX_VL+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [31:0]          inst,
  input  logic [VL_W-1:0]      vl,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic [REG_AW-1:0]    rs1,
  output logic [REG_AW-1:0]    rs2,
  output logic [REG_AW-1:0]    rd,
  output logic [ALU_CW-1:0]    alu_control,
  output logic                 reg_wrt,
  output logic [VL_W-1:0]      elem_base,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic                 uop_last,
  output logic                 busy
);

  localparam logic [VL_W-1:0]   MAX_VL_V = VL_W'(MAX_VL);
  localparam logic [VL_W-1:0]   LANES_V  = VL_W'(NUM_LANES);
  localparam logic [ALU_CW-1:0] NOP_V    = ALU_CW'(ALU_NOP);

  state_e                state_q;
  logic                  uop_valid_q;
  logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
  logic [ALU_CW-1:0]     alu_q;
  logic                  reg_wrt_q;
  logic [VL_W-1:0]       elem_base_q;
  logic [VL_W-1:0]       vl_q;
  logic [NUM_LANES-1:0]  lane_mask_q;
  logic                  uop_last_q;

  logic                  beat_done;
  logic                  accept;
  logic                  load;
  logic [VL_W-1:0]       vl_eff;
  logic [VL_W-1:0]       gen_base_d;
  logic [VL_W-1:0]       gen_vl_d;
  logic [NUM_LANES-1:0]  gen_mask;
  logic                  gen_last;
  logic [ALU_CW-1:0]     alu_d;

  assign beat_done = uop_valid_q & uop_ready;

`ifdef VEC_SEQ_BACK2BACK_EN
  assign inst_ready = (state_q == IDLE) | (beat_done & uop_last_q);
`else
  assign inst_ready = (state_q == IDLE);
`endif

  assign accept = inst_valid & inst_ready;
  // A zero-length instruction is consumed but never loaded.
  assign load   = accept & (vl != '0);
  assign vl_eff = (vl > MAX_VL_V) ? MAX_VL_V : vl;
  assign alu_d  = inst[ALU_LSB +: ALU_CW];

  // The mask generator looks ahead at the beat to be presented next.
  always_comb begin
    gen_base_d = elem_base_q + LANES_V;
    gen_vl_d   = vl_q;
    if (load) begin
      gen_base_d = '0;
      gen_vl_d   = vl_eff;
    end
  end

  vec_lane_mask_gen #(
    .NUM_LANES (NUM_LANES),
    .VL_W      (VL_W)
  ) u_mask_gen (
    .elem_base (gen_base_d),
    .vl        (gen_vl_d),
    .lane_mask (gen_mask),
    .uop_last  (gen_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      uop_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      reg_wrt_q   <= 1'b0;
      elem_base_q <= '0;
      vl_q        <= '0;
      lane_mask_q <= '0;
      uop_last_q  <= 1'b0;
    end else if (load) begin
      state_q     <= ISSUE;
      uop_valid_q <= 1'b1;
      rs1_q       <= inst[RS1_LSB +: REG_AW];
      rs2_q       <= inst[RS2_LSB +: REG_AW];
      rd_q        <= inst[RD_LSB +: REG_AW];
      alu_q       <= alu_d;
      reg_wrt_q   <= (alu_d != NOP_V);
      elem_base_q <= gen_base_d;
      vl_q        <= vl_eff;
      lane_mask_q <= gen_mask;
      uop_last_q  <= gen_last;
    end else if (beat_done) begin
      if (uop_last_q) begin
        state_q     <= IDLE;
        uop_valid_q <= 1'b0;
      end else begin
        elem_base_q <= gen_base_d;
        lane_mask_q <= gen_mask;
        uop_last_q  <= gen_last;
      end
    end
  end

  assign uop_valid   = uop_valid_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign alu_control = alu_q;
  assign reg_wrt     = reg_wrt_q;
  assign elem_base   = elem_base_q;
  assign lane_mask   = lane_mask_q;
  assign uop_last    = uop_last_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vec_uop_sequencer.sv
// Self-checking bench for vec_uop_sequencer: directed scenarios plus random
// traffic against a queue-of-expected-beats reference model.
module tb_vec_uop_sequencer;

  localparam int NUM_LANES = 4;
  localparam int MAX_VL    = 16;
  localparam int REG_AW    = 5;
  localparam int ALU_CW    = 4;
  localparam int VL_W      = $clog2(MAX_VL+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 inst_valid = 1'b0;
  logic                 inst_ready;
  logic [31:0]          inst = '0;
  logic [VL_W-1:0]      vl = '0;
  logic                 uop_valid;
  logic                 uop_ready = 1'b0;
  logic [REG_AW-1:0]    rs1, rs2, rd;
  logic [ALU_CW-1:0]    alu_control;
  logic                 reg_wrt;
  logic [VL_W-1:0]      elem_base;
  logic [NUM_LANES-1:0] lane_mask;
  logic                 uop_last;
  logic                 busy;

  vec_uop_sequencer #(
    .NUM_LANES (NUM_LANES),
    .MAX_VL    (MAX_VL),
    .REG_AW    (REG_AW),
    .ALU_CW    (ALU_CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .vl          (vl),
    .uop_valid   (uop_valid),
    .uop_ready   (uop_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .alu_control (alu_control),
    .reg_wrt     (reg_wrt),
    .elem_base   (elem_base),
    .lane_mask   (lane_mask),
    .uop_last    (uop_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs1, rs2, rd, alu, wrt, base, mask, last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  bit    mon_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: an instruction of length v becomes ceil(min(v,MAX_VL)/NUM_LANES) beats.
  task automatic model_accept(input logic [31:0] w, input int v);
    int eff;
    int nb;
    eff = (v > MAX_VL) ? MAX_VL : v;
    nb  = (eff + NUM_LANES - 1) / NUM_LANES;
    for (int k = 0; k < nb; k++) begin
      beat_t b;
      b.rs1  = int'((w >> 15) & 32'h1F);
      b.rs2  = int'((w >> 20) & 32'h1F);
      b.rd   = int'((w >> 7) & 32'h1F);
      b.alu  = int'(w & 32'hF);
      b.wrt  = (b.alu != 15) ? 1 : 0;
      b.base = k * NUM_LANES;
      b.mask = 0;
      for (int i = 0; i < NUM_LANES; i++)
        if (k * NUM_LANES + i < eff) b.mask = b.mask | (1 << i);
      b.last = (k == nb - 1) ? 1 : 0;
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      check_eq("rst_uop_valid", {31'b0, uop_valid}, 0);
      check_eq("rst_busy", {31'b0, busy}, 0);
      check_eq("rst_lane_mask", 32'(lane_mask), 0);
    end else begin
      mon_ready = (exp_q.size() == 0);
`ifdef VEC_SEQ_BACK2BACK_EN
      if (exp_q.size() == 1 && uop_ready) mon_ready = 1'b1;
`endif
      check_eq("inst_ready", {31'b0, inst_ready}, {31'b0, mon_ready});
      check_eq("uop_valid", {31'b0, uop_valid}, (exp_q.size() != 0) ? 1 : 0);
      check_eq("busy", {31'b0, busy}, (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check_eq("rs1", 32'(rs1), mon_e.rs1);
        check_eq("rs2", 32'(rs2), mon_e.rs2);
        check_eq("rd", 32'(rd), mon_e.rd);
        check_eq("alu_control", 32'(alu_control), mon_e.alu);
        check_eq("reg_wrt", {31'b0, reg_wrt}, mon_e.wrt);
        check_eq("elem_base", 32'(elem_base), mon_e.base);
        check_eq("lane_mask", 32'(lane_mask), mon_e.mask);
        check_eq("uop_last", {31'b0, uop_last}, mon_e.last);
        if (uop_ready) void'(exp_q.pop_front());
      end
      if (inst_valid && mon_ready) model_accept(inst, int'(vl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       uop_ready = 1'b1;
      1:       uop_ready = 1'b0;
      default: uop_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic send(input logic [31:0] w, input logic [VL_W-1:0] v);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    inst = w;
    vl = v;
    inst_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = inst_ready;
      tick();
      guard++;
    end while (!acc && guard < 200);
    check_eq("send_accept", {31'b0, acc}, 1);
    inst_valid = 1'b0;
    inst = $urandom;
    vl = VL_W'($urandom);
    $display("sent inst=%08h vl=%0d", w, v);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_uop_valid"}, {31'b0, uop_valid}, 0);
    check_eq({tag, "_rs1"}, 32'(rs1), 0);
    check_eq({tag, "_rs2"}, 32'(rs2), 0);
    check_eq({tag, "_rd"}, 32'(rd), 0);
    check_eq({tag, "_alu"}, 32'(alu_control), 0);
    check_eq({tag, "_reg_wrt"}, {31'b0, reg_wrt}, 0);
    check_eq({tag, "_elem_base"}, 32'(elem_base), 0);
    check_eq({tag, "_lane_mask"}, 32'(lane_mask), 0);
    check_eq({tag, "_uop_last"}, {31'b0, uop_last}, 0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    #1;
    check_outputs_zero("reset");
    rdy_mode = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // 3 beats, full ready
    send(32'h00208183, 10);
    drain();

    // Stall 5 cycles on the second beat
    send(32'h00208183, 10);
    rdy_mode = 1;
    tick();
    repeat (4) tick();
    rdy_mode = 0;
    tick();
    drain();

    // Zero-length instruction is dropped
    send(32'h00208183, 0);
    repeat (3) tick();

    // Length clipped to MAX_VL
    send(32'h01ABC2D5, 20);
    drain();

    // Asynchronous reset between edges while beats are pending
    send(32'h00208183, 10);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    send(32'h00310201, 6);
    drain();

    // NOP single beat, followed immediately by another instruction
    send(32'h0020818F, 4);
    send(32'h00418282, 8);
    drain();

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      send($urandom, VL_W'($urandom_range(0, 20)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
